difftest_commit_pack: RTL and testbench

- Sits directly upstream of the difftest commit-instruction DPI stage. Consumes raw per-slot retire information from the ROB.
- Compacts valid slots in program order and suppresses r0 writes.
- Registers the result onto the difftest commit ports with 1-cycle latency.
- Also maintains commit and cycle counters, plus a no-commit watchdog for simulation deadlock detection.

---
 rtl/difftest_commit_pack.sv | 119 +++++++++++
 tb/tb_difftest_commit_pack.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/difftest_commit_pack.sv
// rtl/difftest_commit_pack.sv - compacts ROB retire slots onto difftest commit ports
// Registered packing, commit/cycle counters and a no-commit watchdog.
module difftest_commit_pack #(
   parameter int CONFIG_P_COMMIT_WIDTH = 1,
   parameter int CONFIG_WDT_CYCLES     = 1024
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    i_valid,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*30-1:0] i_pc,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] i_insn,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    i_wen,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*5-1:0]  i_wnum,
   input  logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] i_wdata,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    o_valid,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)*30-1:0] o_pc,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] o_insn,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)-1:0]    o_wen,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)*5-1:0]  o_wnum,
   output logic [(1<<CONFIG_P_COMMIT_WIDTH)*32-1:0] o_wdata,
   output logic [31:0]                             o_cmt_cnt,
   output logic [31:0]                             o_cycle_cnt,
   output logic                                    o_wdt_timeout
);

   localparam int CW = CONFIG_P_COMMIT_WIDTH;
   localparam int W  = 1 << CW;
   localparam logic [20:0] WDT_LIM = 21'(CONFIG_WDT_CYCLES);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_TIMEOUT = 1'b1;

   logic [W-1:0]    pk_valid;
   logic [W*30-1:0] pk_pc;
   logic [W*32-1:0] pk_insn;
   logic [W-1:0]    pk_wen;
   logic [W*5-1:0]  pk_wnum;
   logic [W*32-1:0] pk_wdata;
   logic [CW:0]     pos;
   logic [CW:0]     n_cmt;

   logic [31:0]     cmt_cnt_q;
   logic [31:0]     cycle_cnt_q;
   logic [20:0]     idle_q;
   logic [20:0]     idle_d;
   logic [0:0]      state_q;
   logic [0:0]      state_d;

   // pos counts valid slots already placed, so it is the destination index of slot k
   always_comb begin
      pk_valid = '0;
      pk_pc    = '0;
      pk_insn  = '0;
      pk_wen   = '0;
      pk_wnum  = '0;
      pk_wdata = '0;
      pos      = '0;
      for (int k = 0; k < W; k++) begin
         if (i_valid[k]) begin
            for (int j = 0; j < W; j++) begin
               if (pos == j[CW:0]) begin
                  pk_valid[j]         = 1'b1;
                  pk_pc[j*30 +: 30]   = i_pc[k*30 +: 30];
                  pk_insn[j*32 +: 32] = i_insn[k*32 +: 32];
                  pk_wen[j]           = i_wen[k] & (i_wnum[k*5 +: 5] != 5'd0);
                  pk_wnum[j*5 +: 5]   = i_wnum[k*5 +: 5];
                  pk_wdata[j*32 +: 32] = i_wdata[k*32 +: 32];
               end
            end
            pos = pos + (CW+1)'(1);
         end
      end
      n_cmt = pos;
   end

   always_comb begin
      if (n_cmt != '0)
         idle_d = '0;
      else if (idle_q >= WDT_LIM)
         idle_d = WDT_LIM;
      else
         idle_d = idle_q + 21'd1;

      state_d = state_q;
      if (state_q == ST_RUN && idle_d == WDT_LIM)
         state_d = ST_TIMEOUT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid     <= '0;
         o_pc        <= '0;
         o_insn      <= '0;
         o_wen       <= '0;
         o_wnum      <= '0;
         o_wdata     <= '0;
         cmt_cnt_q   <= '0;
         cycle_cnt_q <= '0;
         idle_q      <= '0;
         state_q     <= ST_RUN;
      end else begin
         o_valid     <= pk_valid;
         o_pc        <= pk_pc;
         o_insn      <= pk_insn;
         o_wen       <= pk_wen;
         o_wnum      <= pk_wnum;
         o_wdata     <= pk_wdata;
         cmt_cnt_q   <= cmt_cnt_q + 32'(n_cmt);
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         idle_q      <= idle_d;
         state_q     <= state_d;
      end
   end

   assign o_cmt_cnt     = cmt_cnt_q;
   assign o_cycle_cnt   = cycle_cnt_q;
   assign o_wdt_timeout = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_difftest_commit_pack.sv
// tb/tb_difftest_commit_pack.sv - directed vector bench for difftest_commit_pack
// Main instance uses the default watchdog; a second instance with a 4-cycle watchdog.
module tb_difftest_commit_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_w_n = 1'b0;
   logic [1:0]  valid = '0;
   logic [1:0]  valid_w = '0;
   logic [59:0] pc = '0;
   logic [63:0] insn = '0;
   logic [1:0]  wen = '0;
   logic [9:0]  wnum = '0;
   logic [63:0] wdata = '0;

   logic [1:0]  o_valid, o_wen;
   logic [59:0] o_pc;
   logic [63:0] o_insn, o_wdata;
   logic [9:0]  o_wnum;
   logic [31:0] o_cmt, o_cyc;
   logic        o_wdt;

   logic [1:0]  w_valid, w_wen;
   logic [59:0] w_pc;
   logic [63:0] w_insn, w_wdata;
   logic [9:0]  w_wnum;
   logic [31:0] w_cmt, w_cyc;
   logic        w_wdt;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_cmt = '0;
   logic [31:0] exp_cyc = '0;

   always #5 clk = ~clk;

   difftest_commit_pack #(.CONFIG_P_COMMIT_WIDTH(1), .CONFIG_WDT_CYCLES(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_valid(valid), .i_pc(pc), .i_insn(insn), .i_wen(wen), .i_wnum(wnum), .i_wdata(wdata),
      .o_valid(o_valid), .o_pc(o_pc), .o_insn(o_insn), .o_wen(o_wen), .o_wnum(o_wnum),
      .o_wdata(o_wdata), .o_cmt_cnt(o_cmt), .o_cycle_cnt(o_cyc), .o_wdt_timeout(o_wdt)
   );

   difftest_commit_pack #(.CONFIG_P_COMMIT_WIDTH(1), .CONFIG_WDT_CYCLES(4)) dut_w (
      .clk(clk), .rst_n(rst_w_n),
      .i_valid(valid_w), .i_pc(pc), .i_insn(insn), .i_wen(wen), .i_wnum(wnum), .i_wdata(wdata),
      .o_valid(w_valid), .o_pc(w_pc), .o_insn(w_insn), .o_wen(w_wen), .o_wnum(w_wnum),
      .o_wdata(w_wdata), .o_cmt_cnt(w_cmt), .o_cycle_cnt(w_cyc), .o_wdt_timeout(w_wdt)
   );

   typedef struct {
      logic [1:0]  valid;
      logic [59:0] pc;
      logic [63:0] insn;
      logic [1:0]  wen;
      logic [9:0]  wnum;
      logic [63:0] wdata;
      logic [1:0]  e_valid;
      logic [59:0] e_pc;
      logic [63:0] e_insn;
      logic [1:0]  e_wen;
      logic [9:0]  e_wnum;
      logic [63:0] e_wdata;
      int          inc;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n) exp_cyc = exp_cyc + 32'd1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".valid"}, 64'(o_valid), 64'd0);
      chk({tag, ".pc"},    64'(o_pc),    64'd0);
      chk({tag, ".insn"},  o_insn,       64'd0);
      chk({tag, ".wen"},   64'(o_wen),   64'd0);
      chk({tag, ".wnum"},  64'(o_wnum),  64'd0);
      chk({tag, ".wdata"}, o_wdata,      64'd0);
      chk({tag, ".cmt"},   64'(o_cmt),   64'(exp_cmt));
      chk({tag, ".cyc"},   64'(o_cyc),   64'(exp_cyc));
      chk({tag, ".wdt"},   64'(o_wdt),   64'd0);
   endtask

   initial begin
      vt[0] = '{2'b10, {30'h100, 30'h3FF}, {32'h12345678, 32'hAAAAAAAA}, 2'b11, {5'd3, 5'd7},
                {32'hDEADBEEF, 32'h11111111},
                2'b01, {30'h0, 30'h100}, {32'h0, 32'h12345678}, 2'b01, {5'd0, 5'd3},
                {32'h0, 32'hDEADBEEF}, 1};
      vt[1] = '{2'b11, {30'h201, 30'h200}, {32'h00500293, 32'h00000013}, 2'b11, {5'd5, 5'd0},
                {32'h55, 32'hCAFE0000},
                2'b11, {30'h201, 30'h200}, {32'h00500293, 32'h00000013}, 2'b10, {5'd5, 5'd0},
                {32'h55, 32'hCAFE0000}, 2};
      vt[2] = '{2'b01, {30'h3FFFFFFF, 30'h300}, {32'hFFFFFFFF, 32'h0000ABCD}, 2'b10, {5'd31, 5'd9},
                {32'hFFFFFFFF, 32'h99},
                2'b01, {30'h0, 30'h300}, {32'h0, 32'h0000ABCD}, 2'b00, {5'd0, 5'd9},
                {32'h0, 32'h99}, 1};
      vt[3] = '{2'b00, {30'h123, 30'h456}, {32'h1, 32'h2}, 2'b11, {5'd1, 5'd2}, {32'h3, 32'h4},
                2'b00, 60'h0, 64'h0, 2'b00, 10'h0, 64'h0, 0};
      vt[4] = '{2'b11, {30'h11, 30'h10}, {32'hB, 32'hA}, 2'b00, {5'd4, 5'd6}, {32'h44, 32'h66},
                2'b11, {30'h11, 30'h10}, {32'hB, 32'hA}, 2'b00, {5'd4, 5'd6}, {32'h44, 32'h66}, 2};
      vt[5] = '{2'b11, {30'h3FFFFFFF, 30'h0}, {32'hC, 32'hD}, 2'b11, {5'd31, 5'd1}, {32'hE, 32'hF},
                2'b11, {30'h3FFFFFFF, 30'h0}, {32'hC, 32'hD}, 2'b11, {5'd31, 5'd1}, {32'hE, 32'hF}, 2};

      // reset held three edges, then five idle cycles
      repeat (3) tick();
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle_outputs($sformatf("idle%0d", i));
      end

      for (int v = 0; v < 6; v++) begin
         valid = vt[v].valid; pc = vt[v].pc; insn = vt[v].insn;
         wen = vt[v].wen; wnum = vt[v].wnum; wdata = vt[v].wdata;
         tick();
         exp_cmt = exp_cmt + 32'(vt[v].inc);
         chk($sformatf("v%0d.valid", v), 64'(o_valid), 64'(vt[v].e_valid));
         chk($sformatf("v%0d.pc", v),    64'(o_pc),    64'(vt[v].e_pc));
         chk($sformatf("v%0d.insn", v),  o_insn,       vt[v].e_insn);
         chk($sformatf("v%0d.wen", v),   64'(o_wen),   64'(vt[v].e_wen));
         chk($sformatf("v%0d.wnum", v),  64'(o_wnum),  64'(vt[v].e_wnum));
         chk($sformatf("v%0d.wdata", v), o_wdata,      vt[v].e_wdata);
         chk($sformatf("v%0d.cmt", v),   64'(o_cmt),   64'(exp_cmt));
         chk($sformatf("v%0d.cyc", v),   64'(o_cyc),   64'(exp_cyc));
      end

      // commit counter wrap: preload all-ones, then retire two
      force dut.cmt_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cmt_cnt_q;
      valid = vt[1].valid; pc = vt[1].pc; insn = vt[1].insn;
      wen = vt[1].wen; wnum = vt[1].wnum; wdata = vt[1].wdata;
      tick();
      chk("wrap.cmt", 64'(o_cmt), 64'd1);
      chk("wrap.valid", 64'(o_valid), 64'(2'b11));
      valid = 2'b00;

      // watchdog limit 4: fires on the 4th idle edge, sticky through a commit
      rst_w_n = 1'b0;
      tick();
      rst_w_n = 1'b1;
      valid_w = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("wdt.idle%0d", i), 64'(w_wdt), (i == 4) ? 64'd1 : 64'd0);
      end
      valid_w = 2'b01;
      tick();
      chk("wdt.sticky", 64'(w_wdt), 64'd1);
      chk("wdt.sticky_cmt", 64'(w_cmt), 64'd1);
      valid_w = 2'b00;

      // commit landing on the 4th edge clears the idle count instead
      rst_w_n = 1'b0;
      tick();
      chk("wdt.reset", 64'(w_wdt), 64'd0);
      rst_w_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("wdt.pre%0d", i), 64'(w_wdt), 64'd0);
      end
      valid_w = 2'b10;
      tick();
      chk("wdt.cmt_on_limit", 64'(w_wdt), 64'd0);
      valid_w = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("wdt.re%0d", i), 64'(w_wdt), (i == 4) ? 64'd1 : 64'd0);
      end

      // asynchronous reset between edges with a full bundle in flight
      valid = 2'b11;
      tick();
      chk("async.pre_valid", 64'(o_valid), 64'(2'b11));
      chk("async.pre_wdt", 64'(w_wdt), 64'd1);
      #2;
      rst_n = 1'b0;
      rst_w_n = 1'b0;
      #1;
      chk("async.valid", 64'(o_valid), 64'd0);
      chk("async.pc", 64'(o_pc), 64'd0);
      chk("async.cmt", 64'(o_cmt), 64'd0);
      chk("async.cyc", 64'(o_cyc), 64'd0);
      chk("async.wdt", 64'(w_wdt), 64'd0);
      chk("async.w_cyc", 64'(w_cyc), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
